muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; the multi-cycle successor to the single-cycle ALU control path.
- Decodes funct3 into the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and computes them radix-2, one bit per cycle.
- Sits beside the main ALU in the execute stage; the control unit stalls the pipeline while busy_o is high.
- Operand width is parametrised.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values are even and >= 8.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request valid; accepted only when ready_o=1.
- funct3_i  input  3  operation select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- src_a_i  input  WIDTH  rs1 operand (multiplicand / dividend).
- src_b_i  input  WIDTH  rs2 operand (multiplier / divisor).
- kill_i  input  1  flush; aborts any in-flight operation.
- result_ready_i  input  1  consumer accepts the result.
- ready_o  output  1  unit idle; able to accept start_i.
- busy_o  output  1  operation in flight (CALC, FIX or DONE).
- valid_o  output  1  result_o is valid.
- result_o  output  WIDTH  operation result.

Behaviour:
- Reset: all outputs are driven by registers or by decode of the state register. During reset, ready_o=1, busy_o=0, valid_o=0, result_o=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1 the unit latches funct3_i, src_a_i and src_b_i.
  - Operand magnitudes are taken per op: signed for MULH (both), MULHSU (a only), DIV and REM; unsigned otherwise.
  - The unit records the result-sign flag, loads counter=WIDTH-1 and moves to CALC.
- CALC:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on a WIDTH+1 bit partial remainder.
  - One iteration per cycle. The counter decrements each cycle, and at counter=0 the unit moves to FIX. CALC therefore lasts exactly WIDTH cycles.
- FIX:
  - Applies two's-complement sign correction.
  - Selects low product (MUL), high product (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
  - Registers result_o and moves to DONE.
- DONE:
  - valid_o=1; result_o is held stable.
  - On result_ready_i=1 the unit moves to IDLE the next cycle. result_o keeps its value and valid_o drops.
- Latency: accept at edge 0; valid_o high from cycle WIDTH+2 (34 for WIDTH=32).
- Special cases, resolved in FIX without extra cycles:
  - Divide by zero: quotient = all ones; remainder = src_a.
  - Signed overflow (src_a = -2^(WIDTH-1), src_b = -1): quotient = src_a; remainder = 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- start_i while not IDLE is ignored; no queueing.
- kill_i:
  - In any non-IDLE state, the next state is IDLE; valid_o never asserts for the killed operation.
  - kill_i together with start_i in IDLE: kill has priority and nothing is accepted.
  - kill_i in DONE discards the result.
- Reset asserted mid-operation returns to the reset values asynchronously. The first start_i is accepted in the first clock after deassertion.
- busy_o = (state != IDLE); ready_o = (state == IDLE).

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE at acceptance, the unit goes directly to DONE with the correct result in these cases:
  - divisor = 0;
  - signed overflow;
  - either multiply operand = 0.
  valid_o is then high in the cycle after acceptance (latency 1).
- Undefined: every operation takes the full WIDTH+2 latency, and the special cases resolve in FIX.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB, valid_o first high 34 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0. With MULDIV_EARLY_OUT_EN these give valid_o 1 cycle after accept; without, after 34.
- kill_i pulsed 10 cycles into CALC -> ready_o=1 the next cycle, valid_o stays 0. A new start_i then completes normally. start_i held during CALC -> ignored.
- result_ready_i held low 5 cycles in DONE -> valid_o and result_o stable for all 5. rst_ni pulsed low mid-CALC -> ready_o=1, valid_o=0, result_o=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// Multiply is MSB-first shift-add into a 2*WIDTH accumulator; divide is
// restoring shift-subtract with the remainder in the upper half of that same
// accumulator and the dividend/quotient in the lower half.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, divide by
// zero, signed overflow and multiply by zero finish straight from IDLE.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             kill_i,
    input  logic             result_ready_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     result_q, result_d;

    // ---------------- input decode at acceptance ----------------
    logic             in_is_div, a_signed, b_signed, a_neg, b_neg, neg_in, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             eo_hit;
    logic [WIDTH-1:0] eo_result;

    assign in_is_div = funct3_i[2];
    assign a_signed  = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                       (funct3_i == F_DIV)  || (funct3_i == F_REM);
    assign b_signed  = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
    assign a_neg     = a_signed & src_a_i[WIDTH-1];
    assign b_neg     = b_signed & src_b_i[WIDTH-1];
    // -MIN wraps to MIN, which read unsigned is exactly the needed magnitude
    assign a_mag     = a_neg ? -src_a_i : src_a_i;
    assign b_mag     = b_neg ? -src_b_i : src_b_i;
    // Remainder takes the dividend's sign; everything else the xor of both
    assign neg_in    = (funct3_i == F_REM) ? a_neg : (a_neg ^ b_neg);
    assign b_zero    = (src_b_i == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic eo_divz, eo_ovf, eo_mzero;
    assign eo_divz  = in_is_div & b_zero;
    assign eo_ovf   = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
                      (src_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b_i == '1);
    assign eo_mzero = ~in_is_div & ((src_a_i == '0) | b_zero);
    assign eo_hit   = eo_divz | eo_ovf | eo_mzero;
    // funct3[1] separates remainder from quotient within the divide group
    always_comb begin
        eo_result = '0;
        if (eo_divz)      eo_result = funct3_i[1] ? src_a_i : '1;
        else if (eo_ovf)  eo_result = funct3_i[1] ? '0 : src_a_i;
    end
`else
    assign eo_hit    = 1'b0;
    assign eo_result = '0;
`endif

    // ---------------- one iteration of the datapath ----------------
    logic [2*WIDTH-1:0] mul_acc_nx, div_acc_nx;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    assign mul_acc_nx = {acc_q[2*WIDTH-2:0], 1'b0} +
                        (opb_q[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : '0);
    assign div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge     = (div_shift >= {1'b0, opb_q});
    // Only used when div_ge, where the true difference always fits WIDTH bits
    assign div_diff   = div_shift[WIDTH-1:0] - opb_q;
    assign div_acc_nx = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], div_ge};

    // ---------------- sign fix and result select ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Divide-by-zero quotient is forced; the remainder already equals src_a
    always_comb begin
        fix_result = '0;
        case (op_q)
            F_MUL:                      fix_result = prod_fix[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_result = prod_fix[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:              fix_result = divz_q ? '1 : quo_fix;
            F_REM, F_REMU:              fix_result = rem_fix;
            default:                    fix_result = '0;
        endcase
    end

    // Next-state and datapath update; kill overrides every non-idle state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        divz_d   = divz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    op_d   = funct3_i;
                    opa_d  = a_mag;
                    opb_d  = b_mag;
                    acc_d  = in_is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                    neg_d  = neg_in;
                    divz_d = b_zero;
                    cnt_d  = CNT_W'(WIDTH-1);
                    if (eo_hit) begin
                        result_d = eo_result;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    acc_d = div_acc_nx;
                end else begin
                    acc_d = mul_acc_nx;
                    opb_d = {opb_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = fix_result;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (result_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill_i && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            divz_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            divz_q   <= divz_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q != S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        kill_i;
    logic        result_ready_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int tests = 0;
    int fails = 0;

    logic        pending = 1'b0;
    logic [31:0] exp_result = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .funct3_i(funct3_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .kill_i(kill_i),
        .result_ready_i(result_ready_i), .ready_o(ready_o), .busy_o(busy_o),
        .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic per RV32M rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);            return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);            return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        int lat;
        lat = 34;
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && b == 0) lat = 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
        if (!f[2] && (a == 0 || b == 0)) lat = 1;
`endif
        return lat;
    endfunction

    // Compare process: every cycle out of reset, valid_o only when an op is
    // outstanding, and then result_o must match the model
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (!pending) chk("no_spurious_valid", {31'b0, valid_o}, 32'h0);
            else if (valid_o) chk("result", result_o, exp_result);
        end
    end

    // Drive a request; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start_i    = 1'b1;
        funct3_i   = f;
        src_a_i    = a;
        src_b_i    = b;
        exp_result = model(f, a, b);
        pending    = 1'b1;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
    endtask

    // Wait for valid (bounded), check latency, hold in DONE, then hand off
    task automatic finish(input int n0, input int lat, input int hold);
        int n;
        n = n0;
        while (!valid_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (lat > 0) chk("latency", 32'(n), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'b0, valid_o}, 32'h1);
            @(posedge clk_i); #1;
        end
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        pending        = 1'b0;
        chk("valid_drop", {31'b0, valid_o}, 32'h0);
        chk("ready_back", {31'b0, ready_o}, 32'h1);
        chk("result_kept", result_o, exp_result);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int hold);
        chk(name, model(f, a, b), lit);
        issue(f, a, b);
        finish(1, exp_lat(f, a, b), hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; funct3_i = '0; src_a_i = '0; src_b_i = '0;
        kill_i = 1'b0; result_ready_i = 1'b0;
        #12;
        chk("rst_ready",  {31'b0, ready_o}, 32'h1);
        chk("rst_busy",   {31'b0, busy_o},  32'h0);
        chk("rst_valid",  {31'b0, valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // First start right after reset release
        run_op("mul_7_m3",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulh_min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhu_max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu_m1_2",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
        run_op("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_op("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        5);
        run_op("remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         0);
        run_op("divu_5_0",      3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_5_0",       3'd6, 32'd5,         32'd0,         32'd5,         0);
        run_op("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);
        run_op("mul_zero",      3'd0, 32'd0,         32'd12345,     32'h0,         0);
        run_op("div_7_m2",      3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("rem_7_m2",      3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         0);
        run_op("mulh_m1_m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0);
        run_op("div_m5_0",      3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_m5_0",      3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0);

        // Kill 10 cycles into CALC: back to idle, no valid for that op
        issue(3'd0, 32'd1234, 32'd5678);
        repeat (10) begin @(posedge clk_i); #1; end
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i  = 1'b0;
        pending = 1'b0;
        chk("kill_ready", {31'b0, ready_o}, 32'h1);
        chk("kill_busy",  {31'b0, busy_o},  32'h0);
        repeat (40) begin @(posedge clk_i); #1; end
        run_op("after_kill", 3'd5, 32'd1000, 32'd10, 32'd100, 0);

        // Kill with start in idle: nothing accepted
        start_i = 1'b1; kill_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'd3; src_b_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0; kill_i = 1'b0;
        chk("killstart_busy",  {31'b0, busy_o},  32'h0);
        chk("killstart_ready", {31'b0, ready_o}, 32'h1);
        repeat (3) begin @(posedge clk_i); #1; end

        // start_i held during CALC with other operands is ignored
        issue(3'd5, 32'd100, 32'd7);
        start_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'd50; src_b_i = 32'd3;
        repeat (8) begin @(posedge clk_i); #1; end
        start_i = 1'b0;
        finish(9, 34, 0);

        // Kill in DONE discards the result
        issue(3'd7, 32'd100, 32'd9);
        finish_to_valid();
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i  = 1'b0;
        pending = 1'b0;
        chk("killdone_valid", {31'b0, valid_o}, 32'h0);
        chk("killdone_ready", {31'b0, ready_o}, 32'h1);
        repeat (3) begin @(posedge clk_i); #1; end

        // Asynchronous reset mid-CALC
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) begin @(posedge clk_i); #1; end
        pending = 1'b0;
        rst_ni  = 1'b0;
        #1;
        chk("arst_ready",  {31'b0, ready_o}, 32'h1);
        chk("arst_busy",   {31'b0, busy_o},  32'h0);
        chk("arst_valid",  {31'b0, valid_o}, 32'h0);
        chk("arst_result", result_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_op("after_rst", 3'd0, 32'd300, 32'd300, 32'd90000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic finish_to_valid();
        int n;
        n = 1;
        while (!valid_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("killdone_reached", {31'b0, valid_o}, 32'h1);
    endtask

endmodule
